// File: rtl/alu_pkg.sv
// Shared ALU operation encoding. The execute-stage ALU and the instruction
// decoder both import these constants so the 4-bit control code has one
// definition.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND   = 4'd0;
    localparam alu_op_t ALU_ADD   = 4'd1;
    localparam alu_op_t ALU_SUB   = 4'd2;
    localparam alu_op_t ALU_OR    = 4'd3;
    localparam alu_op_t ALU_XOR   = 4'd4;
    localparam alu_op_t ALU_SLL   = 4'd5;
    localparam alu_op_t ALU_SRL   = 4'd6;
    localparam alu_op_t ALU_SRA   = 4'd7;
    localparam alu_op_t ALU_PASS2 = 4'd8;
    localparam alu_op_t ALU_SLTU  = 4'd9;
    localparam alu_op_t ALU_SLT   = 4'd10;

    // Codes 11..15 are reserved and produce a zero result.
    localparam alu_op_t ALU_RSVD_LO = 4'd11;
    localparam alu_op_t ALU_RSVD_HI = 4'd15;

    function automatic logic is_reserved(input alu_op_t op);
        return op >= ALU_RSVD_LO;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
// Ports:
//   op1  - first operand (rs1 / PC)
//   op2  - second operand (rs2 / immediate); low log2(WIDTH) bits are the shift amount
//   ctrl - operation select (alu_pkg encoding)
//   res  - result
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  alu_op_t          ctrl,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [ShW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = op2[ShW-1:0];
    // Signed compare is done on the full operands, so wrap-around of op1-op2
    // cannot corrupt the SLT result.
    assign lt_signed   = $signed(op1) < $signed(op2);
    assign lt_unsigned = op1 < op2;

    always_comb begin
        res = '0;
        case (ctrl)
            ALU_AND:   res = op1 & op2;
            ALU_ADD:   res = op1 + op2;
            ALU_SUB:   res = op1 - op2;
            ALU_OR:    res = op1 | op2;
            ALU_XOR:   res = op1 ^ op2;
            ALU_SLL:   res = op1 << shamt;
            ALU_SRL:   res = op1 >> shamt;
            ALU_SRA:   res = WIDTH'($signed(op1) >>> shamt);
            ALU_PASS2: res = op2;
            ALU_SLTU:  res = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_SLT:   res = {{(WIDTH-1){1'b0}}, lt_signed};
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU with combinational result/zero and a registered copy.
// Ports:
//   clk    - core clock, only used by res_q/zero_q
//   rst_n  - asynchronous active-low reset of res_q/zero_q
//   op1    - first operand
//   op2    - second operand
//   ctrl   - operation select (alu_pkg encoding)
//   res    - combinational result
//   zero   - combinational flag, high when res == 0
//   res_q  - res sampled at the last rising clk
//   zero_q - zero sampled at the last rising clk
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic [WIDTH-1:0] res_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] res_d;
    logic             zero_d;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op1 (op1),
        .op2 (op2),
        .ctrl(ctrl),
        .res (res)
    );

    assign zero = (res == '0);

    always_comb begin
        res_d  = res;
        zero_d = zero;
    end

    // Reset value of zero_q is 0 even though res_q is 0: it means "nothing
    // captured yet", not a real flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic [31:0] res_q;
    logic        zero_q;

    int tests_run;
    int tests_failed;

    alu #(
        .WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op1   (op1),
        .op2   (op2),
        .ctrl  (ctrl),
        .res   (res),
        .zero  (zero),
        .res_q (res_q),
        .zero_q(zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        op1  = a;
        op2  = b;
        ctrl = c;
        #1;
    endtask

    task automatic test_reset();
        apply(32'd3, 32'd4, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (res_q !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_res_q: got %h expected %h", res_q, 32'd0);
        end
        tests_run++;
        if (zero_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_zero_q: got %b expected %b", zero_q, 1'b0);
        end
        tests_run++;
        if (res !== 32'd7) begin
            tests_failed++;
            $display("FAIL reset_comb_res: got %h expected %h", res, 32'd7);
        end
    endtask

    task automatic test_arith();
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [3:0]  c [6];
        logic [31:0] e [6];
        a = '{32'hFFFFFFF0, 32'hFFFFFFF0, 32'd16, 32'hFFFFFFFB, 32'd16, 32'h7FFFFFFF};
        b = '{32'hFFFFFFFB, 32'd5,        32'd5,  32'hFFFFFFF0, 32'd16, 32'd1};
        c = '{4'd1,         4'd1,         4'd2,   4'd2,         4'd2,   4'd1};
        e = '{32'hFFFFFFEB, 32'hFFFFFFF5, 32'd11, 32'd11,       32'd0,  32'h80000000};
        for (int i = 0; i < 6; i++) begin
            apply(a[i], b[i], c[i]);
            tests_run++;
            if (res !== e[i] || zero !== (e[i] == 32'd0)) begin
                tests_failed++;
                $display("FAIL arith[%0d]: got res=%h zero=%b expected res=%h zero=%b",
                         i, res, zero, e[i], (e[i] == 32'd0));
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [3:0]  c [6];
        logic [31:0] e [6];
        a = '{32'd16, 32'hFFFFFFFB, 32'd16, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFB};
        b = '{32'hFFFFFFFB, 32'd16, 32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF, 32'd16};
        c = '{4'd10, 4'd10, 4'd9, 4'd10, 4'd10, 4'd9};
        e = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 6; i++) begin
            apply(a[i], b[i], c[i]);
            tests_run++;
            if (res !== e[i] || zero !== (e[i] == 32'd0)) begin
                tests_failed++;
                $display("FAIL compare[%0d]: got res=%h zero=%b expected res=%h zero=%b",
                         i, res, zero, e[i], (e[i] == 32'd0));
            end
        end
    endtask

    task automatic test_shift_logic();
        logic [31:0] b [9];
        logic [3:0]  c [9];
        logic [31:0] e [9];
        // op1 fixed at 0x80000010; 0x24 shifts by 4 since bit 5 is ignored
        b = '{32'h24, 32'h24, 32'h24, 32'h0000FFF0, 32'h0000FFF0, 32'h0000FFF0,
              32'h12345000, 32'h24, 32'h1F};
        c = '{4'd7, 4'd6, 4'd5, 4'd0, 4'd3, 4'd4, 4'd8, 4'd13, 4'd7};
        e = '{32'hF8000001, 32'h08000001, 32'h00000100, 32'h00000010, 32'h8000FFF0,
              32'h8000FFE0, 32'h12345000, 32'h00000000, 32'hFFFFFFFF};
        for (int i = 0; i < 9; i++) begin
            apply(32'h80000010, b[i], c[i]);
            tests_run++;
            if (res !== e[i] || zero !== (e[i] == 32'd0)) begin
                tests_failed++;
                $display("FAIL shift_logic[%0d]: got res=%h zero=%b expected res=%h zero=%b",
                         i, res, zero, e[i], (e[i] == 32'd0));
            end
        end
        for (int k = 11; k < 16; k++) begin
            apply(32'hDEADBEEF, 32'h12345678, 4'(k));
            tests_run++;
            if (res !== 32'd0 || zero !== 1'b1) begin
                tests_failed++;
                $display("FAIL reserved[%0d]: got res=%h zero=%b expected res=%h zero=%b",
                         k, res, zero, 32'd0, 1'b1);
            end
        end
    endtask

    task automatic test_regs();
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'd3, 32'd4, 4'd1);
        tests_run++;
        if (res_q !== 32'd0) begin
            tests_failed++;
            $display("FAIL release_before_edge: got %h expected %h", res_q, 32'd0);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (res_q !== 32'd7 || zero_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_capture: got res_q=%h zero_q=%b expected res_q=%h zero_q=%b",
                     res_q, zero_q, 32'd7, 1'b0);
        end
        // Input change between edges must not reach res_q
        apply(32'd9, 32'd1, 4'd1);
        tests_run++;
        if (res_q !== 32'd7) begin
            tests_failed++;
            $display("FAIL hold_between_edges: got %h expected %h", res_q, 32'd7);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [3:0]  c [4];
        logic [31:0] e [4];
        a = '{32'd5, 32'd100, 32'hF0F0F0F0, 32'd1};
        b = '{32'd5, 32'd1,   32'h0F0F0F0F, 32'd31};
        c = '{4'd2,  4'd2,    4'd3,         4'd5};
        e = '{32'd0, 32'd99,  32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(a[i], b[i], c[i]);
            @(posedge clk);
            #1;
            tests_run++;
            if (res_q !== e[i] || zero_q !== (e[i] == 32'd0)) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got res_q=%h zero_q=%b expected res_q=%h zero_q=%b",
                         i, res_q, zero_q, e[i], (e[i] == 32'd0));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        apply(32'd3, 32'd4, 4'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (res_q !== 32'd0 || zero_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_clear: got res_q=%h zero_q=%b expected res_q=%h zero_q=%b",
                     res_q, zero_q, 32'd0, 1'b0);
        end
        tests_run++;
        if (res !== 32'd7 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL comb_during_reset: got res=%h zero=%b expected res=%h zero=%b",
                     res, zero, 32'd7, 1'b0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        op1          = '0;
        op2          = '0;
        ctrl         = '0;
        test_reset();
        test_arith();
        test_compare();
        test_shift_logic();
        test_regs();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Integer arithmetic/logic unit for the RV32 core execute stage.
- Combines two WIDTH-bit operands under a 4-bit control code.
- Result and zero flag are combinational, so the unit adds no pipeline latency.
- A registered copy of both outputs is provided for downstream stages or debug, clocked by the core clock.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.

Ports:
- clk  input  1  core clock; used only by the registered outputs.
- rst_n  input  1  asynchronous, active-low reset.
- op1  input  WIDTH  first operand (rs1 / PC).
- op2  input  WIDTH  second operand (rs2 / immediate).
- ctrl  input  4  operation select (encoding below).
- res  output  WIDTH  combinational result.
- zero  output  1  combinational flag: 1 exactly when res == 0.
- res_q  output  WIDTH  res registered on rising clk.
- zero_q  output  1  zero registered on rising clk.

Behaviour:
- res and zero are purely combinational from op1, op2 and ctrl.
  - No clock or reset dependence.
  - Valid within the same delta/settle time as the inputs.
- ctrl encoding (shared constants):
  - 0 AND
  - 1 ADD: op1+op2, modulo 2^WIDTH, no overflow flag.
  - 2 SUB: op1-op2, modulo 2^WIDTH.
  - 3 OR
  - 4 XOR
  - 5 SLL: op1 << op2[log2(WIDTH)-1:0].
  - 6 SRL: logical right shift, same shift amount.
  - 7 SRA: arithmetic right shift, sign-filled from op1[WIDTH-1].
  - 8 PASS2: res = op2, for LUI.
  - 9 SLTU: unsigned op1<op2 gives 1, else 0, zero-extended.
  - 10 SLT: signed two's-complement op1<op2 gives 1, else 0, zero-extended.
  - 11–15 reserved: res = 0 (zero = 1).
- Shift-amount bits of op2 above log2(WIDTH)-1 are ignored.
- zero reflects res for every op, including SLT/SLTU and reserved codes.
  - It is not a separate compare.
- Signed overflow in ADD/SUB wraps silently.
  - SLT must still be correct across overflow: compare the sign bits, or use sign ^ overflow of the subtraction.
- Registered outputs:
  - rst_n low forces res_q = 0 and zero_q = 0 immediately (asynchronous reset).
  - On rst_n release, the first rising clk loads the current res and zero.
  - Thereafter res_q/zero_q equal res/zero sampled at the most recent rising clk; one-cycle latency, updated every cycle, no enable.
  - Reset asserted mid-operation clears res_q/zero_q at once; the combinational outputs are unaffected.
- No X propagation from reserved codes: the decode has a default arm.

Decomposition:
- Shared package/header holds the 4-bit ALU op constants (ALU_AND … ALU_SLT) and the reserved range.
  - The decoder/control unit uses the same constants.
- One combinational core (alu_core: op1, op2, ctrl -> res) is a natural sub-module.
  - The top level adds the zero compare and the output register.

Test Plan:
- ADD: op1=-16, op2=-5, ctrl=1 -> res=-21 (0xFFFFFFEB), zero=0.
- ADD: op1=-16, op2=5, ctrl=1 -> res=-11.
- SUB:
  - op1=16, op2=5, ctrl=2 -> res=11.
  - op1=-5, op2=-16, ctrl=2 -> res=11.
  - op1=16, op2=16, ctrl=2 -> res=0, zero=1.
- SLT/SLTU, with op1=16, op2=-5:
  - ctrl=10 -> res=0.
  - swapped operands, ctrl=10 -> res=1.
  - op1=16, op2=-5, ctrl=9 -> res=1.
  - op1=0x7FFFFFFF, op2=0x80000000, ctrl=10 -> res=0 (overflow case).
- Shifts/logic, with op1=0x80000010:
  - op2=0x24, ctrl=7 -> res=0xF8000001 (shift 4).
  - ctrl=6 -> 0x08000001.
  - ctrl=5 -> 0x00000100.
  - Reserved ctrl=13 -> res=0, zero=1.
- Registers:
  - With rst_n=0, res_q=0 and zero_q=0 regardless of inputs and clk.
  - After release, ADD 3+4 -> res_q=7 after one rising edge.
  - rst_n pulled low between edges clears res_q=0 without waiting for clk.
